// File: rtl/divider_core.sv
// divider_core: sequential unsigned restoring divider, one quotient bit per
// clock, MSB first, with a start/busy/done handshake.
// Optional feature macro: DIVIDER_REMAINDER_EN adds the Remainder output port
// and its result register. Without it only the quotient is exported.
module divider_core #(
  parameter int DEVIDENT_LENGTH = 10,
  parameter int DIVISOR_LENGTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DEVIDENT_LENGTH-1:0] OperA,
  input  logic [DIVISOR_LENGTH-1:0]  OperD,
  output logic                       busy,
  output logic                       done,
  output logic                       div_by_zero,
`ifdef DIVIDER_REMAINDER_EN
  output logic [DIVISOR_LENGTH-1:0]  Remainder,
`endif
  output logic [DEVIDENT_LENGTH-1:0] Quotient
);

  localparam int CW = $clog2(DEVIDENT_LENGTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]                 r_state;
  logic [CW-1:0]              r_count;
  // Holds the dividend while it is consumed MSB first; quotient bits are
  // shifted in at the bottom, so after the last step it holds the quotient.
  logic [DEVIDENT_LENGTH-1:0] r_dividend;
  logic [DIVISOR_LENGTH-1:0]  r_divisor;
  // The stored partial remainder is always below the divisor, so its top
  // (borrow) bit only exists in the shifted/trial values below.
  logic [DIVISOR_LENGTH-1:0]  r_partRem;
  logic                       r_zero;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_dbz;
  logic [DEVIDENT_LENGTH-1:0] r_quotient;
`ifdef DIVIDER_REMAINDER_EN
  logic [DIVISOR_LENGTH-1:0]  r_remainder;
`endif

  logic [DIVISOR_LENGTH:0]    w_shifted;
  logic [DIVISOR_LENGTH:0]    w_diff;
  logic                       w_fits;

  // Trial subtraction: a set top bit of the difference is the borrow.
  assign w_shifted = {r_partRem, r_dividend[DEVIDENT_LENGTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_divisor};
  assign w_fits    = ~w_diff[DIVISOR_LENGTH];

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign Quotient    = r_quotient;
`ifdef DIVIDER_REMAINDER_EN
  assign Remainder   = r_remainder;
`endif

  // Control FSM and datapath: accept, iterate one bit per clock, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_partRem  <= '0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_quotient <= '0;
`ifdef DIVIDER_REMAINDER_EN
      r_remainder <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= OperA;
            r_divisor  <= OperD;
            r_partRem  <= '0;
            r_count    <= CW'(DEVIDENT_LENGTH);
            r_busy     <= 1'b1;
            r_dbz      <= 1'b0;
            r_zero     <= (OperD == '0);
            r_state    <= (OperD == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_partRem  <= w_fits ? w_diff[DIVISOR_LENGTH-1:0]
                               : w_shifted[DIVISOR_LENGTH-1:0];
          r_dividend <= {r_dividend[DEVIDENT_LENGTH-2:0], w_fits};
          r_count    <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_quotient <= r_zero ? '1 : r_dividend;
`ifdef DIVIDER_REMAINDER_EN
          r_remainder <= r_zero ? r_dividend[DIVISOR_LENGTH-1:0] : r_partRem;
`endif
          r_dbz   <= r_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_core.sv
// Self-checking bench for divider_core: table-driven vectors with a result
// scoreboard, plus hand-written sequences for held start and mid-run reset.
module tb_divider_core;

  localparam int DW = 10;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] OperA;
  logic [VW-1:0] OperD;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] Quotient;
`ifdef DIVIDER_REMAINDER_EN
  logic [VW-1:0] Remainder;
`endif

  typedef struct {
    int unsigned q;
    int unsigned r;
    bit          dbz;
  } exp_t;

  typedef struct {
    int unsigned a;
    int unsigned d;
    int unsigned q;
    int unsigned r;
    bit          dbz;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          total = 0;
  int          bad   = 0;
  int unsigned lastQ = 0;

  always #5 clk = ~clk;

  divider_core #(
    .DEVIDENT_LENGTH(DW),
    .DIVISOR_LENGTH (VW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .OperA      (OperA),
    .OperD      (OperD),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
`ifdef DIVIDER_REMAINDER_EN
    .Remainder  (Remainder),
`endif
    .Quotient   (Quotient)
  );

  // One comparison: counts it, reports a mismatch on one line.
  task automatic checkOutput(input string name, input int unsigned act,
                             input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge and record the expected result.
  task automatic applyStimulus(input int unsigned a, input int unsigned d,
                               input int unsigned q, input int unsigned r,
                               input bit dbz);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    OperA = DW'(a);
    OperD = VW'(d);
    e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    OperA = DW'($urandom);
    OperD = VW'($urandom);
  endtask

  // Called at the negedge right after the accepting edge. Waits (bounded)
  // for done, optionally holding start high with scrambled operands, then
  // checks latency, busy behaviour and the scoreboard entry.
  task automatic waitDone(input int expLat, input bit scramble);
    int   c;
    bit   held;
    bit   stayBusy;
    exp_t e;
    c = 0; held = 1'b1; stayBusy = 1'b1;
    checkOutput("busyAfterAccept", 32'(busy), 1);
    while (!done && c < 40) begin
      if (32'(Quotient) != lastQ) held = 1'b0;
      if (!busy) stayBusy = 1'b0;
      if (scramble) begin
        OperA = DW'($urandom);
        OperD = VW'($urandom);
      end
      @(negedge clk);
      c++;
    end
    checkOutput("latency", c, expLat);
    checkOutput("quotientHeldWhileBusy", 32'(held), 1);
    checkOutput("busyThroughRun", 32'(stayBusy), 1);
    checkOutput("busyAtDone", 32'(busy), 0);
    if (sb.size() == 0) begin
      checkOutput("scoreboardHasEntry", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("quotient", 32'(Quotient), e.q);
      checkOutput("divByZero", 32'(div_by_zero), 32'(e.dbz));
`ifdef DIVIDER_REMAINDER_EN
      checkOutput("remainder", 32'(Remainder), e.r);
`endif
    end
    lastQ = 32'(Quotient);
  endtask

  initial begin
    int  a;
    int  d;
    bit  sawDone;

    vecs[0]  = '{1,    1,  1,    0, 1'b0, 11};
    vecs[1]  = '{21,   7,  3,    0, 1'b0, 11};
    vecs[2]  = '{28,   7,  4,    0, 1'b0, 11};
    vecs[3]  = '{14,   2,  7,    0, 1'b0, 11};
    vecs[4]  = '{12,   3,  4,    0, 1'b0, 11};
    vecs[5]  = '{12,   3,  4,    0, 1'b0, 11};
    vecs[6]  = '{1000, 31, 32,   8, 1'b0, 11};
    vecs[7]  = '{1023, 1,  1023, 0, 1'b0, 11};
    vecs[8]  = '{5,    31, 0,    5, 1'b0, 11};
    vecs[9]  = '{5,    0,  1023, 5, 1'b1, 1};
    vecs[10] = '{21,   7,  3,    0, 1'b0, 11};

    rst = 1'b1; start = 1'b0; OperA = '0; OperD = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetDivByZero", 32'(div_by_zero), 0);
    checkOutput("resetQuotient", 32'(Quotient), 0);
`ifdef DIVIDER_REMAINDER_EN
    checkOutput("resetRemainder", 32'(Remainder), 0);
`endif
    rst = 1'b0;

    // Table-driven vectors, each started after the previous done.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dbz);
      waitDone(vecs[i].lat, 1'b0);
      @(negedge clk);
      checkOutput("donePulseWidth", 32'(done), 0);
      checkOutput("quotientAfterDone", 32'(Quotient), vecs[i].q);
    end

    // A few random nonzero divisors against the arithmetic identity.
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 1023);
      d = $urandom_range(1, 31);
      applyStimulus(a, d, a / d, a % d, 1'b0);
      waitDone(11, 1'b0);
    end

    // start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1; OperA = DW'(1000); OperD = VW'(31);
    sb.push_back('{32, 8, 1'b0});
    @(negedge clk);
    waitDone(11, 1'b1);
    OperA = DW'(21); OperD = VW'(7);
    sb.push_back('{3, 0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    OperA = DW'($urandom); OperD = VW'($urandom);
    waitDone(11, 1'b0);

    // Reset four cycles into a run aborts it with no done.
    @(negedge clk);
    start = 1'b1; OperA = DW'(1000); OperD = VW'(31);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortQuotient", 32'(Quotient), 0);
    checkOutput("abortDone", 32'(done), 0);
`ifdef DIVIDER_REMAINDER_EN
    checkOutput("abortRemainder", 32'(Remainder), 0);
`endif
    rst = 1'b0;
    lastQ = 0;
    sawDone = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterAbort", 32'(sawDone), 0);
    applyStimulus(28, 7, 4, 0, 1'b0);
    waitDone(11, 1'b0);

    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
